// File: rtl/pio_sm_sequencer_if.sv
// Decode-side bundle for the PIO sequencer. The sequencer drives pc and exec_strobe.
// Decode/execute returns the per-instruction delay, stall and jump information.
interface pio_sm_sequencer_if #(
    parameter int PC_W    = 5,
    parameter int DELAY_W = 5
);
    logic [PC_W-1:0]    pc;
    logic               exec_strobe;
    logic [DELAY_W-1:0] instr_delay;
    logic               instr_stall;
    logic               jmp_taken;
    logic [PC_W-1:0]    jmp_target;

    modport master (
        output pc, exec_strobe,
        input  instr_delay, instr_stall, jmp_taken, jmp_target
    );

    modport slave (
        input  pc, exec_strobe,
        output instr_delay, instr_stall, jmp_taken, jmp_target
    );
endinterface

// File: rtl/pio_sm_sequencer.sv
// PC/timing sequencer for one PIO state machine: issue, stall, delay, jump and wrap.
// Optional PIO_SEQ_EXEC_CNT_EN adds a committed-instruction counter (exec_count_o).
module pio_sm_sequencer #(
    parameter int PC_W    = 5,
    parameter int DELAY_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_i,
    input  logic            restart_i,
    input  logic            penable_i,
    input  logic [PC_W-1:0] wrap_top_i,
    input  logic [PC_W-1:0] wrap_bottom_i,
    pio_sm_sequencer_if.master dec,
    output logic            delay_busy_o,
    output logic            stalled_o
`ifdef PIO_SEQ_EXEC_CNT_EN
    ,
    output logic [31:0]     exec_count_o
`endif
);
    typedef enum logic {ST_RUN, ST_DELAY} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, next_pc;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic               stalled_q, stalled_d;
    logic               tick, issue;

    assign tick            = enable_i & penable_i;
    assign issue           = tick & ~restart_i & ~reset & (state_q == ST_RUN);
    assign dec.exec_strobe = issue;
    assign dec.pc          = pc_q;
    assign delay_busy_o    = (state_q == ST_DELAY);
    assign stalled_o       = stalled_q;

    // A taken jump wins over wrap, so a JMP sitting at wrap_top goes to its target.
    always_comb begin
        if (dec.jmp_taken)             next_pc = dec.jmp_target;
        else if (pc_q == wrap_top_i)   next_pc = wrap_bottom_i;
        else                           next_pc = pc_q + PC_W'(1);
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        stalled_d = stalled_q;
        if (restart_i) begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            stalled_d = 1'b0;
        end else if (tick) begin
            unique case (state_q)
                ST_RUN: begin
                    // Stalled ticks never start the delay; it begins once the stall resolves.
                    if (dec.instr_stall) begin
                        stalled_d = 1'b1;
                    end else begin
                        stalled_d = 1'b0;
                        pc_d      = next_pc;
                        if (dec.instr_delay != '0) begin
                            cnt_d   = dec.instr_delay;
                            state_d = ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    cnt_d = cnt_q - DELAY_W'(1);
                    if (cnt_q <= DELAY_W'(1)) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= '0;
            cnt_q     <= '0;
            stalled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            stalled_q <= stalled_d;
        end
    end

`ifdef PIO_SEQ_EXEC_CNT_EN
    logic [31:0] exec_count_q;
    assign exec_count_o = exec_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            exec_count_q <= '0;
        else if (restart_i)                   exec_count_q <= '0;
        else if (issue && !dec.instr_stall)   exec_count_q <= exec_count_q + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pio_sm_sequencer.sv
// Directed bench for pio_sm_sequencer: stimulus pushes expected issues, a negedge monitor
// pops and compares them against every exec_strobe.
module tb_pio_sm_sequencer;
    localparam int PC_W = 5, DELAY_W = 5;

    logic clk, reset, enable, restart, penable;
    logic [PC_W-1:0] wrap_top, wrap_bottom;
    logic delay_busy, stalled;
`ifdef PIO_SEQ_EXEC_CNT_EN
    logic [31:0] exec_count;
`endif

    pio_sm_sequencer_if #(.PC_W(PC_W), .DELAY_W(DELAY_W)) dec_if ();

    pio_sm_sequencer #(.PC_W(PC_W), .DELAY_W(DELAY_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .restart_i    (restart),
        .penable_i    (penable),
        .wrap_top_i   (wrap_top),
        .wrap_bottom_i(wrap_bottom),
        .dec          (dec_if.master),
        .delay_busy_o (delay_busy),
        .stalled_o    (stalled)
`ifdef PIO_SEQ_EXEC_CNT_EN
        ,
        .exec_count_o (exec_count)
`endif
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            stl;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Monitor: every strobe must match the head of the queue; an expected issue with no strobe fails.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (dec_if.exec_strobe) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_issue: got strobe at pc=%0d expected none", dec_if.pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_pc", 32'(dec_if.pc), 32'(e.pc));
                    chk("issue_stalled", 32'(stalled), 32'(e.stl));
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_chk++;
                $display("FAIL missing_issue: got no strobe expected issue at pc=%0d", e.pc);
            end
        end
    end

    task automatic tk();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pen, input logic stall, input logic [DELAY_W-1:0] dly,
                         input logic jt, input logic [PC_W-1:0] tgt);
        penable               = pen;
        dec_if.instr_stall    = stall;
        dec_if.instr_delay    = dly;
        dec_if.jmp_taken      = jt;
        dec_if.jmp_target     = tgt;
        restart               = 1'b0;
    endtask

    task automatic issue(input logic [PC_W-1:0] epc, input logic est, input logic stall,
                         input logic [DELAY_W-1:0] dly, input logic jt, input logic [PC_W-1:0] tgt);
        drive(1'b1, stall, dly, jt, tgt);
        exp_q.push_back('{pc: epc, stl: est});
        tk();
    endtask

    task automatic idle(input logic pen);
        drive(pen, 1'b0, '0, 1'b0, '0);
        tk();
    endtask

    task automatic chk_st(input string nm, input logic [PC_W-1:0] epc, input logic ebusy, input logic estl);
        chk({nm, "_pc"}, 32'(dec_if.pc), 32'(epc));
        chk({nm, "_busy"}, 32'(delay_busy), 32'(ebusy));
        chk({nm, "_stalled"}, 32'(stalled), 32'(estl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; penable = 1'b1; restart = 1'b0;
        wrap_top = 5'd31; wrap_bottom = 5'd0;
        dec_if.instr_delay = '0; dec_if.instr_stall = 1'b0;
        dec_if.jmp_taken = 1'b0; dec_if.jmp_target = '0;
        #3;
        chk("reset_strobe", 32'(dec_if.exec_strobe), 32'd0);
        chk_st("reset", 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Free-running count with full wrap 31 -> 0
        for (int i = 0; i < 33; i++) issue(5'(i % 32), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_st("count", 5'd1, 1'b0, 1'b0);

        // penable 1-in-4
        for (int k = 0; k < 4; k++) begin
            issue(5'(1 + k), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            for (int j = 0; j < 3; j++) idle(1'b0);
        end
        chk_st("pen4", 5'd5, 1'b0, 1'b0);

        // Delay of 2 at pc=3
        issue(5'd5, 1'b0, 1'b0, 5'd0, 1'b1, 5'd3);
        issue(5'd3, 1'b0, 1'b0, 5'd2, 1'b0, 5'd0);
        chk_st("dly_a", 5'd4, 1'b1, 1'b0);
        idle(1'b1);
        chk_st("dly_b", 5'd4, 1'b1, 1'b0);
        idle(1'b1);
        chk_st("dly_c", 5'd4, 1'b0, 1'b0);
        issue(5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Stall three ticks at pc=5, then commit with delay 1
        issue(5'd5, 1'b0, 1'b1, 5'd1, 1'b0, 5'd0);
        chk_st("stall1", 5'd5, 1'b0, 1'b1);
        issue(5'd5, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0);
        issue(5'd5, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0);
        chk_st("stall3", 5'd5, 1'b0, 1'b1);
        issue(5'd5, 1'b1, 1'b0, 5'd1, 1'b0, 5'd0);
        chk_st("unstall", 5'd6, 1'b1, 1'b0);
        idle(1'b1);
        chk_st("unstall_dly", 5'd6, 1'b0, 1'b0);
        issue(5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Wrap and jump priority
        wrap_top = 5'd7; wrap_bottom = 5'd2;
        issue(5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("wrap_pc", 32'(dec_if.pc), 32'd2);
        issue(5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
        issue(5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7);
        chk("jmp_at_top_pc", 32'(dec_if.pc), 32'd7);
        wrap_bottom = 5'd7;
        issue(5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("self_loop_pc", 32'(dec_if.pc), 32'd7);
        wrap_bottom = 5'd2;
        issue(5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31);
        issue(5'd31, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("pc31_rollover", 32'(dec_if.pc), 32'd0);
        wrap_top = 5'd3; wrap_bottom = 5'd10;
        for (int i = 0; i < 4; i++) issue(5'(i), 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("wrap_up_pc", 32'(dec_if.pc), 32'd10);

        // Restart aborts a 31-tick delay; pc=9 during the delay
        wrap_top = 5'd31; wrap_bottom = 5'd0;
        issue(5'd10, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        issue(5'd8, 1'b0, 1'b0, 5'd31, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk_st("long_dly", 5'd9, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        restart = 1'b1;
        tk();
        restart = 1'b0;
        chk_st("restart", 5'd9, 1'b0, 1'b0);
`ifdef PIO_SEQ_EXEC_CNT_EN
        chk("cnt_restart", exec_count, 32'd0);
`endif
        issue(5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
`ifdef PIO_SEQ_EXEC_CNT_EN
        chk("cnt_one", exec_count, 32'd1);
`endif

        // Restart in RUN with a tick suppresses the issue and clears stalled
        issue(5'd10, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0);
        drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        restart = 1'b1;
        tk();
        restart = 1'b0;
        chk_st("restart_run", 5'd10, 1'b0, 1'b0);
        issue(5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // enable=0 freezes RUN and DELAY
        enable = 1'b0;
        idle(1'b1); idle(1'b1);
        chk_st("dis_run", 5'd11, 1'b0, 1'b0);
        enable = 1'b1;
        issue(5'd11, 1'b0, 1'b0, 5'd1, 1'b0, 5'd0);
        enable = 1'b0;
        idle(1'b1); idle(1'b1);
        chk_st("dis_dly", 5'd12, 1'b1, 1'b0);
        enable = 1'b1;
        idle(1'b1);
        chk_st("en_dly", 5'd12, 1'b0, 1'b0);
        issue(5'd12, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Asynchronous reset in the middle of a delay
        issue(5'd13, 1'b0, 1'b0, 5'd5, 1'b0, 5'd0);
        idle(1'b1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_strobe", 32'(dec_if.exec_strobe), 32'd0);
        chk_st("midrst", 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        issue(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk("post_rst_pc", 32'(dec_if.pc), 32'd1);

        idle(1'b0); idle(1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pio_sm_sequencer.md
Name: pio_sm_sequencer

Overview:
Program-counter and timing sequencer for one PIO state machine. It sits directly downstream of the clock divider and consumes its penable tick. Each tick it decides whether the instruction at pc issues, stalls, or is held off by an instruction delay. It then advances pc, honouring JMP, wrap_top→wrap_bottom wrap-around and restart. Instruction decode and execute logic sits further downstream, reads pc and drives instr_delay, instr_stall and jmp_*.

Parameters:
PC_W, 5, program counter width (32-entry instruction memory)
DELAY_W, 5, width of the delay field / delay counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  SM enable (CTRL.SM_ENABLE); low freezes all state
restart  input  1  one-cycle SM restart pulse, synchronous
penable  input  1  clock-enable tick from the clock divider; all sequencing advances only when high
instr_delay  input  DELAY_W  delay field of the instruction at pc, side-set bits already masked off
instr_stall  input  1  instruction at pc cannot complete this tick (blocking PUSH/PULL/WAIT)
jmp_taken  input  1  instruction at pc is a JMP whose condition is true
jmp_target  input  PC_W  JMP destination
wrap_top  input  PC_W  EXECCTRL.WRAP_TOP
wrap_bottom  input  PC_W  EXECCTRL.WRAP_BOTTOM
pc  output  PC_W  current instruction address, registered
exec_strobe  output  1  combinational; instruction at pc issues this cycle
delay_busy  output  1  registered; sequencer is in DELAY state
stalled  output  1  registered; last issue was stalled (EXECCTRL.EXEC_STALLED)

Behaviour:
- Reset (async): pc=0, state=RUN, delay counter=0, delay_busy=0, stalled=0. exec_strobe is 0 while reset is asserted.
- tick = enable & penable. With enable=0: pc, state, delay counter and stalled are all held, and exec_strobe=0.
- States are RUN and DELAY. delay_busy = (state==DELAY).
- RUN on tick: exec_strobe=1.
  - If instr_stall=1: pc held, stalled<=1, stay in RUN. Instr_delay and jmp_taken are ignored. The same instruction re-issues on the next tick.
  - If instr_stall=0: stalled<=0 and pc<=next_pc.
    - If instr_delay!=0: counter<=instr_delay and go to DELAY.
    - Otherwise stay in RUN.
- RUN, no tick: exec_strobe=0 and nothing changes.
- DELAY on tick: exec_strobe=0 and counter decrements. When counter==1 at the tick, go to RUN. Exactly instr_delay ticks are spent in DELAY, so the next issue occurs on the (instr_delay+1)th tick after the issue.
- Delay is applied only after the stall resolves; stalled cycles never count toward delay.
- next_pc priority:
  - jmp_taken → jmp_target. This means a taken JMP located at wrap_top does not wrap.
  - else pc==wrap_top → wrap_bottom.
  - else pc+1 modulo 2^PC_W (31→0).
- wrap_bottom > wrap_top is legal; only equality with wrap_top triggers a wrap.
- wrap_top==wrap_bottom: pc stays put on a non-jump issue, giving a single-instruction loop.
- restart (synchronous, highest priority, acts regardless of tick/enable):
  - state<=RUN, counter<=0, stalled<=0, pc unchanged.
  - exec_strobe=0 in the restart cycle.
  - restart during DELAY aborts the remaining delay.
- Reset mid-operation: everything returns to reset values immediately.
- penable held constantly 1 (divider bypassed): one issue per clk when not stalled or delayed.

Optional Feature:
PIO_SEQ_EXEC_CNT_EN:
- With the macro defined: adds output exec_count [31:0], reset 0. It increments by 1 on every exec_strobe with instr_stall=0 (a committed instruction), wraps 0xFFFFFFFF→0, and clears on restart.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then enable=1, penable=1, delay=0, no stall/jmp, wrap_top=31, wrap_bottom=0 → pc 0,1,2,…,31,0; exec_strobe high every cycle.
- penable pulses 1-in-4, enable=1 → pc increments once per 4 clk; exec_strobe high only on penable cycles.
- Issue at pc=3 with instr_delay=2, penable=1 → delay_busy high 2 cycles, exec_strobe 0,0; next issue at pc=4 on the 3rd cycle.
- instr_stall=1 for 3 ticks at pc=5, then 0 with delay=1 → pc stays 5 and stalled=1 for 3 issues. Then pc=6, stalled=0, 1 delay tick.
- wrap_top=7, wrap_bottom=2: issue at 7 → pc=2. Issue at 7 with jmp_taken, jmp_target=7 → pc=7. Issue at 31 with wrap_top=7 → pc=0.
- restart during a 31-tick delay at pc=9 → next cycle delay_busy=0, stalled=0, pc=9, and the issue resumes on the next tick. With PIO_SEQ_EXEC_CNT_EN, exec_count=0 after restart.
